shift_deser: RTL
================

// Module: shift_deser
// PURPOSE
//  Serial-to-parallel receiver: the receive-side counterpart of the parallel-load shift-out register.
//  Collects WIDTH bits from a serial stream and frames them with a start marker.
//  Presents each completed word on a valid/ready output with a one-word holding register.
//  Sits between a serial link front-end (bit strobe + data) and a word-wide consumer/FIFO.
// PARAMETERS
//  WIDTH       8  word width in bits; must be >= 2 (elaboration $error otherwise)
//  CONTINUOUS  0  1: after a word completes, the next strobed bit starts a new word without frame; 0: return to IDLE
// PORTS
//  clk        in   1      clock
//  aclr       in   1      reset: asynchronous, active-high
//  ena        in   1      bit strobe; d/frame/dir sampled only when ena=1
//  frame      in   1      marks the strobed bit as bit 0 of a new word
//  dir        in   1      1: MSB first; 0: LSB first; sampled with the first bit of each word
//  d          in   1      serial data
//  m_data     out  WIDTH  completed word (holding register)
//  m_valid    out  1      m_data valid
//  m_ready    in   1      consumer accepts m_data when m_valid && m_ready
//  busy       out  1      1 while in SHIFT (partial word held)
//  overrun    out  1      1-cycle pulse: completed word dropped because holding reg full
//  frame_err  out  1      1-cycle pulse: frame seen mid-word; partial word discarded
// BEHAVIOUR
//  Reset: state=IDLE, shift reg=0, bit count=0, dir latch=0, m_data=0, m_valid=0, busy=0, overrun=0, frame_err=0.
//  States: IDLE, SHIFT.
//  - IDLE, ena&&frame: latch dir; shift in d; cnt=1; go SHIFT.
//    IDLE, ena&&!frame: bit ignored; no state change.
//  - SHIFT, ena&&!frame: shift in d; cnt++.
//  - SHIFT, ena&&frame: frame_err pulse; restart as in IDLE (re-latch dir, cnt=1).
//  - Shift rule, latched dir=1: sr <= {sr[WIDTH-2:0], d}.
//  - Shift rule, latched dir=0: sr <= {d, sr[WIDTH-1:1]}.
//  - Word completion: the edge that accepts bit WIDTH (cnt==WIDTH-1 before that edge).
//    The completed word is the post-shift value; sr/cnt are not reset (stale bits fully overwritten).
//  - After completion:
//    - CONTINUOUS=0: cnt=0, go IDLE.
//    - CONTINUOUS=1: cnt=0, stay SHIFT with dir latch held. A frame on the next bit is legal there (no frame_err when cnt==0).
//  - Output handoff, at completion:
//    - !m_valid or m_ready: m_data<=word, m_valid=1 from the next cycle.
//    - m_valid && !m_ready: word dropped, m_data unchanged, overrun pulse next cycle.
//  - m_valid clears the cycle after m_valid&&m_ready with no simultaneous completion.
//  - Latency: last bit edge -> m_valid high 1 cycle later; never combinational from d.
//  - Simultaneous accept+completion: new word loaded, m_valid stays 1, no overrun.
//  - dir changes mid-word have no effect until the next framed first bit.
//  - cnt width = $clog2(WIDTH); no wrap past WIDTH-1.
//  - aclr mid-word: partial word and held output lost; all outputs return to reset values asynchronously.
// STRUCTURE
//  - Package shift_pkg: typedef enum logic {IDLE, SHIFT} deser_state_t.
//  - Package shift_pkg: function for cnt width, $clog2 with minimum 1.
//  - One sub-module, deser_hold: WIDTH-wide holding register with load/valid/ready/overrun logic.
//  - shift_deser keeps the FSM, counter and shift register inline.
// TESTING  (WIDTH=8 unless noted)
//  1. dir=1, frame on first bit, bits 1,0,1,0,0,1,0,1, m_ready=1
//     -> m_data=8'hA5, m_valid 1 cycle after bit 8, then low; busy=0.
//  2. dir=0, same bits -> m_data=8'hA5 reversed = 8'hA5? Use bits 1,1,0,0,0,0,0,0
//     -> m_data=8'h03.
//  3. m_ready=0, two framed words 8'h11 then 8'h22
//     -> m_data stays 8'h11, m_valid=1, one overrun pulse on 2nd completion.
//  4. frame asserted on bit 5 of a word, then 8 bits of 8'h3C
//     -> frame_err pulse once, m_data=8'h3C, no word from the aborted partial.
//  5. CONTINUOUS=1, one frame then 16 bits (8'hF0, 8'h0F)
//     -> two m_valid events in order.
//     CONTINUOUS=0, same stimulus -> only 8'hF0; remaining bits ignored.
//  6. aclr pulse after bit 4, and separately while m_valid=1
//     -> all outputs 0 immediately; next framed word received correctly.

Source files
------------

// File: rtl/shift_deser_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel receiver.
package shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } deser_state_t;

  // Bit-count width; never narrower than one bit so the counter always exists.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/shift_deser_if.sv
// Serial-in / word-out bundle between a link front-end, the receiver and its consumer.
interface shift_deser_if #(
  parameter int WIDTH = 8
);
  logic             ena;
  logic             frame;
  logic             dir;
  logic             d;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             busy;
  logic             overrun;
  logic             frame_err;

  modport slave (
    input  ena, frame, dir, d, m_ready,
    output m_data, m_valid, busy, overrun, frame_err
  );

  modport master (
    output ena, frame, dir, d, m_ready,
    input  m_data, m_valid, busy, overrun, frame_err
  );
endinterface

// File: rtl/shift_deser_hold.sv
// One-word output holding register: loads completed words, drops them when full.
module deser_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load) begin
      // A word arriving in the same cycle the old one is taken simply replaces it.
      if (!valid_q || m_ready) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && m_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign m_data  = data_q;
  assign m_valid = valid_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: framed bit collection with selectable bit order,
// handing completed words to a one-deep valid/ready holding register.
module shift_deser #(
  parameter int WIDTH      = 8,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic          clk,
  input  logic          aclr,
  shift_deser_if.slave  bus
);
  import shift_pkg::*;

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("shift_deser: WIDTH must be at least 2");
    end
  endgenerate

  deser_state_t     state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             frame_err_q, frame_err_d;
  logic             shift_dir;
  logic             do_shift;
  logic             word_done;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    frame_err_d = 1'b0;
    shift_dir   = dir_q;
    do_shift    = 1'b0;
    word_done   = 1'b0;
    if (bus.ena) begin
      if (bus.frame) begin
        // cnt==0 in SHIFT only happens at a continuous-mode word boundary, where a frame is legal.
        frame_err_d = (state_q == SHIFT) && (cnt_q != '0);
        dir_d       = bus.dir;
        shift_dir   = bus.dir;
        do_shift    = 1'b1;
        cnt_d       = CW'(1);
        state_d     = SHIFT;
      end else if (state_q == SHIFT) begin
        do_shift = 1'b1;
        if (cnt_q == LAST) begin
          word_done = 1'b1;
          cnt_d     = '0;
          state_d   = CONTINUOUS ? SHIFT : IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
    if (do_shift) begin
      sr_d = shift_dir ? {sr_q[WIDTH-2:0], bus.d} : {bus.d, sr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      frame_err_q <= frame_err_d;
    end
  end

  // The completed word is the post-shift value, so hand over sr_d rather than sr_q.
  deser_hold #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk     (clk),
    .aclr    (aclr),
    .load    (word_done),
    .word    (sr_d),
    .m_ready (bus.m_ready),
    .m_data  (bus.m_data),
    .m_valid (bus.m_valid),
    .overrun (bus.overrun)
  );

  assign bus.busy      = (state_q == SHIFT);
  assign bus.frame_err = frame_err_q;

endmodule
